seq_detector: RTL and testbench
===============================

Name: seq_detector

Overview:
Parametrised serial pattern detector. It is the successor to the fixed single-pattern Moore `fsm` in lab0.
- Runtime-loadable pattern of 1..PATTERN_W bits.
- Overlapping or non-overlapping match mode.
- Input-valid qualifier.
- Saturating match counter.
- Sits between a serial bit source and status/interrupt logic.

Parameters:
PATTERN_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match_count
LEN_W, $clog2(PATTERN_W+1), width of cfg_len (derived; do not override)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is sampled only when high
in_bit  input  1  serial data bit
cfg_load  input  1  one-cycle pulse: latch cfg_* and flush history
cfg_pattern  input  PATTERN_W  pattern; bit [cfg_len-1] arrives first, bit [0] arrives last
cfg_len  input  LEN_W  active pattern length, legal range 1..PATTERN_W
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after each match
match  output  1  one-cycle registered pulse on pattern completion
match_count  output  CNT_W  saturating count of matches since reset/cfg_load
fill  output  LEN_W  number of valid history bits, saturates at PATTERN_W

Behaviour:
- Reset (reset_n low, asynchronous):
  - history=0, fill=0, match=0, match_count=0.
  - pat_q=0, len_q=1, ovl_q=1.
- Configuration:
  - cfg_load high at an edge: pat_q<=cfg_pattern, len_q<=cfg_len, ovl_q<=cfg_overlap.
  - Same edge: fill<=0, match<=0, match_count<=0.
  - in_valid is ignored on that edge; cfg_load has priority.
  - cfg_len=0 or >PATTERN_W is clamped to 1 / PATTERN_W when latched.
- Sampling (in_valid high, cfg_load low):
  - history<={history[PATTERN_W-2:0], in_bit}, newest bit at LSB.
  - fill<=min(fill+1, PATTERN_W).
- Match condition, evaluated on the next state:
  - next_fill>=len_q, and
  - next_history[len_q-1:0]==pat_q[len_q-1:0]; bits above len_q are masked.
- Match response:
  - match is registered. It is high for exactly the one cycle following the edge that sampled the completing bit; latency 1 clock from that edge.
  - Overlap mode (ovl_q=1): fill keeps counting. A suffix of the match may start the next match.
  - Non-overlap mode (ovl_q=0): fill<=0 on the matching edge, so the next match needs len_q fresh bits.
  - match_count<=match_count+1 on every match, saturating at all-ones (no wrap).
- in_valid low: history, fill and match_count hold; match<=0. Gaps do not break a partial match.
- Internal state machine, fill-driven:
  - FILLING: fill<len_q.
  - ARMED: fill>=len_q. Every valid bit is a candidate.
  - Transition ARMED->FILLING on a non-overlap match or on cfg_load.
- len_q=1: every valid bit equal to pat_q[0] matches, in both modes.
- Reset mid-stream: all state is cleared immediately, and any pending match pulse drops the same instant.

Optional Feature:
Macro SEQDET_STICKY_EN.
- Defined: adds output port match_sticky (1 bit).
  - Set on any match; stays high until cfg_load or reset.
  - Has priority over clear when a match and cfg_load coincide? No: cfg_load wins, sticky <=0.
- Not defined: port absent, no extra flop.

Decomposition:
- Package seq_detector_pkg holds:
  - typedef enum {FILLING, ARMED} seqdet_state_t.
  - Function clamp_len().
  - Default constants PATTERN_W_DEF=8, CNT_W_DEF=8.
- One sub-module, sat_counter (parameter W; ports clock, reset_n, clr, inc, count). It implements match_count saturation and is reused elsewhere.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then idle -> match=0, match_count=0, fill=0. Asserting reset_n=0 mid-stream clears them immediately, without waiting for an edge.
- Overlap, load pattern 4'b1101 len=4 ovl=1; stream 1,1,0,1,1,0,1 -> match pulses after bit 4 and after bit 7; match_count=2.
- Non-overlap, same pattern ovl=0, same stream -> match after bit 4 only; match_count=1. Appending 1,1,0,1 gives a second match after bit 11.
- Gaps: stream 1,1,0,1 with in_valid low 3 cycles between bits 2 and 3 -> single match, one cycle after bit 4; fill holds during gaps.
- Reload: cfg_load (pattern 3'b101, len=3) after 1,1,0 of a 1101 sequence, then bit 1 -> no match; then 0,1 -> fill=3, match asserted.
- Saturation, CNT_W=2, len=1, pattern=1, ovl=1: stream 6 ones -> match every valid cycle; match_count stops at 3.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared types, defaults and length clamp for seq_detector
package seq_detector_pkg;

  localparam int PATTERN_W_DEF = 8;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic {FILLING, ARMED} seqdet_state_t;

  // Out-of-range lengths are forced into 1..max_len rather than rejected.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial pattern detector; optional match_sticky output under SEQDET_STICKY_EN
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LEN_W     = $clog2(PATTERN_W + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
`ifdef SEQDET_STICKY_EN
  output logic                 match_sticky,
`endif
  output logic [LEN_W-1:0]     fill
);

  localparam logic [PATTERN_W-1:0] ONES     = '1;
  localparam logic [LEN_W:0]       FILL_MAX = (LEN_W + 1)'(PATTERN_W);

  seqdet_state_t        state_q, state_d;
  logic [PATTERN_W-1:0] history, hist_d;
  logic [PATTERN_W-1:0] pat_q, mask;
  logic [LEN_W-1:0]     len_q, fill_d;
  logic [LEN_W:0]       fill_inc;
  logic                 ovl_q, match_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILLING;
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b1;
    end else if (cfg_load) begin
      state_q <= FILLING;
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
      pat_q   <= cfg_pattern;
      len_q   <= LEN_W'(clamp_len(int'(cfg_len), PATTERN_W));
      ovl_q   <= cfg_overlap;
    end else begin
      state_q <= state_d;
      history <= hist_d;
      fill    <= fill_d;
      match   <= match_d;
    end
  end

  // Once ARMED, fill can only grow until a flush, so the length test need not be repeated.
  always_comb begin
    state_d  = state_q;
    hist_d   = history;
    fill_d   = fill;
    match_d  = 1'b0;
    mask     = ~(ONES << len_q);
    fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
    if (in_valid) begin
      hist_d = {history[PATTERN_W-2:0], in_bit};
      fill_d = (fill_inc > FILL_MAX) ? FILL_MAX[LEN_W-1:0] : fill_inc[LEN_W-1:0];
      if ((state_q == ARMED) || (fill_inc >= {1'b0, len_q})) begin
        state_d = ARMED;
        if ((hist_d & mask) == (pat_q & mask)) begin
          match_d = 1'b1;
          if (!ovl_q) begin
            fill_d  = '0;
            state_d = FILLING;
          end
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_count (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (cfg_load),
    .inc    (match_d),
    .count  (match_count)
  );

`ifdef SEQDET_STICKY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_sticky <= 1'b0;
    end else if (cfg_load) begin
      match_sticky <= 1'b0;
    end else if (match_d) begin
      match_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector against a bit-queue model
module tb_seq_detector;

  localparam int PW = 8;
  localparam int CW = 2;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic [LW-1:0] fill;
`ifdef SEQDET_STICKY_EN
  logic          match_sticky;
`endif

  seq_detector #(.PATTERN_W(PW), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .match      (match),
    .match_count(match_count),
`ifdef SEQDET_STICKY_EN
    .match_sticky(match_sticky),
`endif
    .fill       (fill)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  // Model: the bits seen since the last flush (newest at the back), at most PW of them.
  bit            mq[$];
  logic [PW-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  int            m_cnt;
  bit            m_match;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pat = '0;
    m_len = 1;
    m_ovl = 1'b1;
    m_cnt = 0;
    m_match = 1'b0;
  endfunction

  function automatic void model_load(input logic [PW-1:0] p, input int l, input bit o);
    mq.delete();
    m_pat = p;
    m_len = (l < 1) ? 1 : ((l > PW) ? PW : l);
    m_ovl = o;
    m_cnt = 0;
    m_match = 1'b0;
  endfunction

  function automatic void model_sample(input bit b);
    bit hit;
    mq.push_back(b);
    if (mq.size() > PW) void'(mq.pop_front());
    m_match = 1'b0;
    if (mq.size() >= m_len) begin
      hit = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (mq[mq.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
      if (hit) begin
        m_match = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      check("match", 32'(match), 32'(m_match));
      check("match_count", 32'(match_count), 32'(m_cnt));
      check("fill", 32'(fill), 32'(mq.size()));
    end
  end

  task automatic drive(input logic v, input logic b);
    in_valid = v;
    in_bit = b;
    cfg_load = 1'b0;
    @(posedge clock);
    #1;
    if (v) model_sample(b);
    else m_match = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [PW-1:0] p, input int l, input logic o, input logic v);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = LW'(l);
    cfg_overlap = o;
    in_valid = v;
    in_bit = 1'b1;
    @(posedge clock);
    #1;
    model_load(p, l, o);
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // bits[n-1] is sent first.
  task automatic stream(input int n, input logic [15:0] bits);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    #1;
    check("rst_match", 32'(match), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_fill", 32'(fill), 0);
    cmp_en = 1'b1;

    // Power-on config is len 1, pattern 0.
    drive(1'b1, 1'b0);
    check("rst_cfg_match", 32'(match), 1);
    drive(1'b1, 1'b1);
    check("rst_cfg_nomatch", 32'(match), 0);

    // Overlap mode.
    load(8'b1101, 4, 1'b1, 1'b0);
    stream(3, 16'b110);
    drive(1'b1, 1'b1);
    check("ovl_m1", 32'(match), 1);
    stream(2, 16'b10);
    check("ovl_gap_nomatch", 32'(match), 0);
    drive(1'b1, 1'b1);
    check("ovl_m2", 32'(match), 1);
    check("ovl_count", 32'(match_count), 2);

    // Non-overlap mode.
    load(8'b1101, 4, 1'b0, 1'b0);
    stream(4, 16'b1101);
    check("novl_m1", 32'(match), 1);
    check("novl_fill0", 32'(fill), 0);
    stream(3, 16'b101);
    check("novl_no2", 32'(match), 0);
    check("novl_count1", 32'(match_count), 1);
    stream(3, 16'b110);
    drive(1'b1, 1'b1);
    check("novl_m2", 32'(match), 1);
    check("novl_count2", 32'(match_count), 2);

    // Gaps, with in_valid high on the load edge (must be ignored).
    load(8'b1101, 4, 1'b1, 1'b1);
    check("load_ign_fill", 32'(fill), 0);
    stream(2, 16'b11);
    repeat (3) drive(1'b0, 1'b0);
    check("gap_fill", 32'(fill), 2);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("gap_match", 32'(match), 1);
    drive(1'b0, 1'b0);
    check("gap_drop", 32'(match), 0);
    check("gap_count", 32'(match_count), 1);

    // Reload mid-pattern.
    load(8'b1101, 4, 1'b1, 1'b0);
    stream(3, 16'b110);
    load(8'b101, 3, 1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("reload_nomatch", 32'(match), 0);
    stream(2, 16'b01);
    check("reload_fill", 32'(fill), 3);
    check("reload_match", 32'(match), 1);

    // Saturation of the 2-bit counter.
    load(8'b1, 1, 1'b1, 1'b0);
    stream(6, 16'b111111);
    check("sat_count", 32'(match_count), 3);
    check("sat_match", 32'(match), 1);

    // Length clamping: 0 -> 1, 15 -> 8.
    load(8'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check("clamp_lo", 32'(match), 1);
    load(8'hA5, 15, 1'b1, 1'b0);
    stream(8, 16'hA5);
    check("clamp_hi_match", 32'(match), 1);
    check("clamp_hi_fill", 32'(fill), 8);
    stream(2, 16'b10);
    check("fill_sat", 32'(fill), 8);

    // Asynchronous reset while a match pulse is showing.
    load(8'b1101, 4, 1'b1, 1'b0);
    stream(4, 16'b1101);
    check("pre_rst_match", 32'(match), 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_match", 32'(match), 0);
    check("async_count", 32'(match_count), 0);
    check("async_fill", 32'(fill), 0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    stream(3, 16'b010);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
